// File: rtl/btn_pkg.sv
// Shared constants for push-button conditioning: FSM state encodings and
// default debounce/hold thresholds, reused by the other pad-input conditioners.
package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE        = 2'd0;
    localparam btn_state_t DEB_PRESS   = 2'd1;
    localparam btn_state_t PRESSED     = 2'd2;
    localparam btn_state_t DEB_RELEASE = 2'd3;

    localparam int          BTN_WIDTH  = 22;
    // 25 ms of stable samples at 100 MHz
    localparam logic [21:0] BTN_K_DEB  = 22'd2_500_000;
    localparam logic [21:0] BTN_K_HOLD = 22'd4_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing an asynchronous level into clk_i.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_sync_p0;
    logic r_sync_p1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= d_i;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign q_o = r_sync_p1;

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the sweep-start button, emitting one pulse per accepted press.
// Define BTN_HOLD_EN to build the long-press detector driving hold_o.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int               Width  = BTN_WIDTH,
    parameter logic [Width-1:0] K_DEB  = Width'(BTN_K_DEB),
    parameter logic [Width-1:0] K_HOLD = Width'(BTN_K_HOLD)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    output logic pulse_o,
    output logic level_o,
    output logic hold_o
);

    localparam logic [Width-1:0] CNT_ONE = Width'(1);

    logic             w_btn_s;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [Width-1:0] r_cnt;
    logic [Width-1:0] w_cnt_nxt;
    logic [Width-1:0] w_cnt_inc;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_level;
    logic             w_level_nxt;

    sync_2ff u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (button_i),
        .q_o   (w_btn_s)
    );

    // The counter is always below K_DEB inside a DEB_* state, so the increment never wraps.
    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    if (K_DEB == CNT_ONE) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DEB_PRESS;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            DEB_PRESS: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == K_DEB) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            PRESSED: begin
                if (!w_btn_s) begin
                    if (K_DEB == CNT_ONE) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = DEB_RELEASE;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            DEB_RELEASE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == K_DEB) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == DEB_RELEASE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_level <= w_level_nxt;
        end
    end

    assign pulse_o = r_pulse;
    assign level_o = r_level;

`ifdef BTN_HOLD_EN
    logic [Width-1:0] r_hold_cnt;
    logic [Width-1:0] w_hold_inc;
    logic             r_hold;

    assign w_hold_inc = r_hold_cnt + CNT_ONE;

    // Counts only while settled in PRESSED; a release bounce pauses it without clearing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hold_cnt <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            if ((r_state == IDLE) || (r_state == DEB_PRESS)) begin
                r_hold_cnt <= '0;
            end else if ((r_state == PRESSED) && (r_hold_cnt != K_HOLD)) begin
                r_hold_cnt <= w_hold_inc;
                r_hold     <= (w_hold_inc == K_HOLD);
            end
        end
    end

    assign hold_o = r_hold;
`else
    logic w_unused_k_hold;

    assign w_unused_k_hold = ^K_HOLD;
    assign hold_o          = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (K_DEB=4, K_HOLD=10, Width=8).
module tb_button_conditioner;

    localparam int KD = 4;
    localparam int KH = 10;

`ifdef BTN_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk_i    = 1'b0;
    logic rst_i    = 1'b0;
    logic button_i = 1'b0;
    logic pulse_o;
    logic level_o;
    logic hold_o;

    always #5 clk_i = ~clk_i;

    button_conditioner #(
        .Width  (8),
        .K_DEB  (8'd4),
        .K_HOLD (8'd10)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .button_i (button_i),
        .pulse_o  (pulse_o),
        .level_o  (level_o),
        .hold_o   (hold_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: synchronizer delay line plus a run-length view of the debounce rule.
    logic m_q0, m_q1, m_lvl, m_pulse, m_hold;
    int   m_run, m_hc;

    int   edge_idx, npulse, nhold, nlvl, pulse_edge, hold_edge, fall_edge;
    logic prev_lvl = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_q0 = 1'b0; m_q1 = 1'b0; m_lvl = 1'b0;
        m_pulse = 1'b0; m_hold = 1'b0;
        m_run = 0; m_hc = 0;
    endtask

    task automatic model_edge(input logic b);
        logic s;
        s = m_q1;
        m_hold = 1'b0;
        if (!m_lvl) m_hc = 0;
        else if (m_run == 0 && m_hc < KH) begin
            m_hc++;
            m_hold = (m_hc == KH);
        end
        m_pulse = 1'b0;
        if (s == m_lvl) m_run = 0;
        else begin
            m_run++;
            if (m_run == KD) begin
                m_lvl   = ~m_lvl;
                m_run   = 0;
                m_pulse = m_lvl;
            end
        end
        m_q1 = m_q0;
        m_q0 = b;
    endtask

    task automatic scen_start();
        edge_idx = 0; npulse = 0; nhold = 0; nlvl = 0;
        pulse_edge = -1; hold_edge = -1; fall_edge = -1;
    endtask

    task automatic cycle(input logic b);
        button_i = b;
        @(posedge clk_i);
        if (!rst_i) model_reset();
        else model_edge(b);
        #1;
        check("pulse", pulse_o, m_pulse);
        check("level", level_o, m_lvl);
        check("hold", hold_o, HOLD_EN ? m_hold : 1'b0);
        edge_idx++;
        if (pulse_o) begin npulse++; pulse_edge = edge_idx; end
        if (hold_o) begin nhold++; hold_edge = edge_idx; end
        if (level_o) nlvl++;
        if (prev_lvl && !level_o) fall_edge = edge_idx;
        prev_lvl = level_o;
        @(negedge clk_i);
    endtask

    task automatic run(input logic b, input int n);
        repeat (n) cycle(b);
    endtask

    // Called at a falling edge; asserts reset, checks outputs clear at once, then releases.
    task automatic apply_reset(input logic b, input int n);
        rst_i    = 1'b0;
        button_i = b;
        #1;
        model_reset();
        check("rst_pulse", pulse_o, 0);
        check("rst_level", level_o, 0);
        check("rst_hold", hold_o, 0);
        prev_lvl = level_o;
        @(negedge clk_i);
        run(b, n);
        rst_i = 1'b1;
    endtask

    initial begin
        model_reset();
        scen_start();
        @(negedge clk_i);
        apply_reset(1'b0, 3);
        run(1'b0, 5);

        // Clean press and release
        scen_start();
        run(1'b1, 20);
        check("clean_npulse", npulse, 1);
        check("clean_pulse_edge", pulse_edge, KD + 2);
        check("clean_nhold", nhold, HOLD_EN ? 1 : 0);
        scen_start();
        run(1'b0, 10);
        check("clean_fall_edge", fall_edge, KD + 2);

        // Bouncy press 1,2,1,3 then stable high
        scen_start();
        run(1'b1, 1); run(1'b0, 2); run(1'b1, 1); run(1'b0, 3);
        check("bounce_quiet_pulse", npulse, 0);
        check("bounce_quiet_level", nlvl, 0);
        scen_start();
        run(1'b1, 15);
        check("bounce_npulse", npulse, 1);
        check("bounce_pulse_edge", pulse_edge, KD + 2);
        run(1'b0, 10);

        // Release bounce: short low glitch keeps level high
        run(1'b1, 12);
        scen_start();
        run(1'b0, 3); run(1'b1, 8);
        check("relb_npulse", npulse, 0);
        check("relb_no_fall", fall_edge, -1);
        check("relb_level", level_o, 1);
        scen_start();
        run(1'b0, 10);
        check("relb_fall_edge", fall_edge, KD + 2);

        // Reset mid-debounce (counter at 2), button held through release
        run(1'b1, 4);
        apply_reset(1'b1, 2);
        scen_start();
        run(1'b1, 10);
        check("rstdeb_npulse", npulse, 1);
        check("rstdeb_pulse_edge", pulse_edge, KD + 2);
        check("rstdeb_level_before", level_o, 1);
        apply_reset(1'b1, 1);
        run(1'b0, 6);

        // Long press
        scen_start();
        run(1'b1, 30);
        check("long_npulse", npulse, 1);
        check("long_nhold", nhold, HOLD_EN ? 1 : 0);
        check("long_hold_edge", hold_edge, HOLD_EN ? KD + 2 + KH : -1);
        run(1'b0, 10);

        // Single-cycle glitch
        scen_start();
        run(1'b1, 1); run(1'b0, 10);
        check("glitch_npulse", npulse, 0);
        check("glitch_nlevel", nlvl, 0);
        check("glitch_nhold", nhold, 0);

        // Random bouncing runs against the model
        for (int i = 0; i < 60; i++) begin
            run(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
        end
        run(1'b0, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
